// File: rtl/crossbar_rr_arbiter.sv
// Packet-locked round-robin arbiter for one crossbar egress port; grant is held until release or hold timeout.
// Optional high-priority class with its own pointer is enabled by defining ARB_PRIO_EN.
module crossbar_rr_arbiter #(
    parameter int PORT_NUM = 10,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 2048,
    parameter int CNT_W    = 12
) (
    input  logic                i_sys_clk,
    input  logic                i_sys_rst_n,
    input  logic [PORT_NUM-1:0] i_req,
    input  logic                i_release,
`ifdef ARB_PRIO_EN
    input  logic [PORT_NUM-1:0] i_hi_pri,
`endif
    output logic [PORT_NUM-1:0] o_grant,
    output logic                o_grant_valid,
    output logic [IDX_W-1:0]    o_grant_idx,
    output logic                o_timeout
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t              r_state, w_state_nxt;
    logic [PORT_NUM-1:0] r_grant, w_grant_nxt;
    logic [PORT_NUM-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_timeout, w_timeout_nxt;
    logic                w_hold_exp, w_end;
    logic [PORT_NUM-1:0] w_owner_rot, w_arb_req, w_arb_ptr, w_pick;
    logic [IDX_W-1:0]    w_idx;

    // First requester at or above ptr; the doubled vector lets the borrow wrap past bit PORT_NUM-1.
    function automatic logic [PORT_NUM-1:0] f_pick(input logic [PORT_NUM-1:0] req,
                                                   input logic [PORT_NUM-1:0] ptr);
        logic [2*PORT_NUM-1:0] dbl;
        logic [2*PORT_NUM-1:0] msk;
        dbl = {req, req};
        msk = dbl & ~(dbl - {{PORT_NUM{1'b0}}, ptr});
        return msk[2*PORT_NUM-1:PORT_NUM] | msk[PORT_NUM-1:0];
    endfunction

    assign w_hold_exp  = (MAX_HOLD != 0) && (r_cnt == CNT_W'(MAX_HOLD - 1));
    assign w_end       = (r_state == S_GRANT) && (i_release || w_hold_exp);
    assign w_owner_rot = {r_grant[PORT_NUM-2:0], r_grant[PORT_NUM-1]};

`ifdef ARB_PRIO_EN
    logic [PORT_NUM-1:0] r_ptr_hi, w_ptr_hi_nxt, w_hi_req;
    logic                r_own_hi, w_own_hi_nxt, w_use_hi;

    assign w_hi_req     = i_req & i_hi_pri;
    assign w_use_hi     = |w_hi_req;
    assign w_ptr_nxt    = (w_end && !r_own_hi) ? w_owner_rot : r_ptr;
    assign w_ptr_hi_nxt = (w_end &&  r_own_hi) ? w_owner_rot : r_ptr_hi;
    assign w_arb_req    = w_use_hi ? w_hi_req : i_req;
    assign w_arb_ptr    = w_use_hi ? w_ptr_hi_nxt : w_ptr_nxt;
    assign w_own_hi_nxt = (r_state == S_IDLE || w_end) ? w_use_hi : r_own_hi;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_ptr_hi <= PORT_NUM'(1);
            r_own_hi <= 1'b0;
        end else begin
            r_ptr_hi <= w_ptr_hi_nxt;
            r_own_hi <= w_own_hi_nxt;
        end
    end
`else
    assign w_ptr_nxt = w_end ? w_owner_rot : r_ptr;
    assign w_arb_req = i_req;
    assign w_arb_ptr = w_ptr_nxt;
`endif

    assign w_pick = f_pick(w_arb_req, w_arb_ptr);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_ptr     <= PORT_NUM'(1);
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|i_req) w_state_nxt = S_GRANT;
            S_GRANT: if (w_end) w_state_nxt = (|i_req) ? S_GRANT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt   = r_grant;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = w_pick;
                w_cnt_nxt   = '0;
            end
            S_GRANT: begin
                if (w_end) begin
                    w_grant_nxt   = w_pick;
                    w_cnt_nxt     = '0;
                    // A release landing on the timeout cycle is an ordinary release.
                    w_timeout_nxt = w_hold_exp && !i_release;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_grant_nxt = '0;
        endcase
    end

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (r_grant[i]) w_idx = w_idx | IDX_W'(i);
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_valid = |r_grant;
    assign o_grant_idx   = w_idx;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_crossbar_rr_arbiter.sv
// Scoreboard bench for crossbar_rr_arbiter: directed stimulus queues expected grant events,
// a negedge monitor pops and compares each grant change or timeout pulse (define ARB_PRIO_EN for the priority case).
module tb_crossbar_rr_arbiter;

    localparam int N = 10;

    typedef struct {
        int         cyc;
        logic [N-1:0] grant;
        logic       tmo;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         rel;
`ifdef ARB_PRIO_EN
    logic [N-1:0] hi_pri;
`endif
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [3:0]   grant_idx;
    logic         timeout;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  sb[$];
    logic [N-1:0] last_grant = '0;

    crossbar_rr_arbiter #(.PORT_NUM(N), .IDX_W(4), .MAX_HOLD(16), .CNT_W(12)) dut (
        .i_sys_clk     (clk),
        .i_sys_rst_n   (rst_n),
        .i_req         (req),
        .i_release     (rel),
`ifdef ARB_PRIO_EN
        .i_hi_pri      (hi_pri),
`endif
        .o_grant       (grant),
        .o_grant_valid (grant_valid),
        .o_grant_idx   (grant_idx),
        .o_timeout     (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic push(input int c, input logic [N-1:0] g, input logic t);
        ev_t e;
        e.cyc = c; e.grant = g; e.tmo = t;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse release for one cycle; the new owner (or idle) is expected on the next cycle.
    task automatic do_release(input logic [N-1:0] g);
        rel = 1'b1;
        push(cyc + 1, g, 1'b0);
        tick(1);
        rel = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_grant", 32'(grant), 0);
        check("rst_valid", 32'(grant_valid), 0);
        check("rst_idx", 32'(grant_idx), 0);
        check("rst_timeout", 32'(timeout), 0);
    endtask

    // Monitor: any change of o_grant or a timeout pulse is one event.
    always @(negedge clk) begin
        if (grant !== last_grant || timeout === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 32'(grant), 32'(last_grant));
                check("unexpected_timeout", 32'(timeout), 0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_grant", 32'(grant), 32'(e.grant));
                check("ev_valid", 32'(grant_valid), 32'(|e.grant));
                check("ev_idx", 32'(grant_idx), idx_of(e.grant));
                check("ev_timeout", 32'(timeout), 32'(e.tmo));
            end
        end
        last_grant = grant;
    end

    initial begin
        int g;
        rst_n = 1'b1; req = '0; rel = 1'b0;
`ifdef ARB_PRIO_EN
        hi_pri = '0;
`endif
        #2 rst_n = 1'b0;
        tick(2);
        check_reset_outputs();
        rst_n = 1'b1;
        tick(2);

        // Fairness: all request, release two cycles after each grant.
        req = 10'h3FF;
        push(cyc + 1, 10'h001, 1'b0);
        tick(1);
        for (int i = 0; i < N; i++) begin
            tick(2);
            rel = 1'b1;
            push(cyc + 1, 10'h001 << ((i + 1) % N), 1'b0);
            tick(1);
            rel = 1'b0;
        end

        // Wrap: reach bit 9, then 0 and back to 9.
        req = 10'h200;
        do_release(10'h200);
        req = 10'h201;
        do_release(10'h001);
        do_release(10'h200);

        // No bubble between back-to-back grants.
        req = 10'h004;
        do_release(10'h004);
        req = 10'h00C;
        do_release(10'h008);

        // Timeout after 16 held cycles, then release coinciding with the second timeout.
        req = 10'h001;
        do_release(10'h001);
        g = cyc;
        req = 10'h003;
        push(g + 16, 10'h002, 1'b1);
        tick(16);
        tick(15);
        do_release(10'h001);

        // Go idle; a release in IDLE must produce nothing.
        req = '0;
        do_release(10'h000);
        rel = 1'b1;
        tick(1);
        rel = 1'b0;
        tick(2);

        // Reset mid-grant, then single-cycle grant latency after reset.
        req = 10'h004;
        push(cyc + 1, 10'h004, 1'b0);
        tick(2);
        rst_n = 1'b0;
        push(cyc, 10'h000, 1'b0);
        #1;
        check_reset_outputs();
        tick(2);
        rst_n = 1'b1;
        push(cyc + 1, 10'h004, 1'b0);
        tick(1);
        // Sole requester is re-granted on timeout.
        push(cyc + 16, 10'h004, 1'b1);
        tick(16);
        req = '0;
        do_release(10'h000);
        tick(2);

`ifdef ARB_PRIO_EN
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        req = 10'h3FF;
        hi_pri = 10'h020;
        push(cyc + 1, 10'h020, 1'b0);
        tick(2);
        hi_pri = '0;
        do_release(10'h001);
        do_release(10'h002);
        do_release(10'h004);
        req = '0;
        do_release(10'h000);
        tick(2);
`endif

        tick(3);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
